// File: rtl/init_command_sequencer_pkg.sv
// Shared encodings for the 8259A init/operation command sequencer:
// FSM states, OCW2 command codes, write-decode kinds and command bit positions.
package init_command_sequencer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned VEC_W  = 5;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned LVL_W  = 3;

    // ICW1 bit positions
    localparam int unsigned ICW1_IC4_BIT  = 0;
    localparam int unsigned ICW1_SNGL_BIT = 1;
    localparam int unsigned ICW1_LTIM_BIT = 3;
    localparam int unsigned ICW1_SEL_BIT  = 4;

    // ICW4 bit positions (D0 uPM is not used by this block)
    localparam int unsigned ICW4_AEOI_BIT = 1;
    localparam int unsigned ICW4_MS_BIT   = 2;
    localparam int unsigned ICW4_BUF_BIT  = 3;
    localparam int unsigned ICW4_SFNM_BIT = 4;

    // OCW2 / OCW3 bit positions
    localparam int unsigned OCW2_CMD_LSB  = 5;
    localparam int unsigned OCW2_LVL_LSB  = 0;
    localparam int unsigned OCW3_SEL_BIT  = 3;
    localparam int unsigned OCW3_RIS_BIT  = 0;
    localparam int unsigned OCW3_RR_BIT   = 1;
    localparam int unsigned OCW3_P_BIT    = 2;
    localparam int unsigned OCW3_SMM_BIT  = 5;
    localparam int unsigned OCW3_ESMM_BIT = 6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } seq_state_e;

    typedef enum logic [CMD_W-1:0] {
        OCW2_ROT_AEOI_CLR = 3'b000,
        OCW2_NS_EOI       = 3'b001,
        OCW2_SP_EOI       = 3'b011,
        OCW2_ROT_AEOI_SET = 3'b100,
        OCW2_ROT_NS_EOI   = 3'b101,
        OCW2_SET_PRIO     = 3'b110,
        OCW2_ROT_SP_EOI   = 3'b111
    } ocw2_cmd_e;

    typedef enum logic [2:0] {
        WR_NONE = 3'd0,
        WR_ICW1 = 3'd1,
        WR_OCW2 = 3'd2,
        WR_OCW3 = 3'd3,
        WR_A0   = 3'd4
    } wr_kind_e;

    typedef struct packed {
        logic              a0;
        logic [DATA_W-1:0] data;
    } cpu_wr_t;

    // Classify one CPU write by A0 and the D4/D3 select bits.
    function automatic wr_kind_e decode_write(input logic strobe, input cpu_wr_t wr);
        if (!strobe)                  return WR_NONE;
        if (wr.a0)                    return WR_A0;
        if (wr.data[ICW1_SEL_BIT])    return WR_ICW1;
        if (wr.data[OCW3_SEL_BIT])    return WR_OCW3;
        return WR_OCW2;
    endfunction

endpackage

// File: rtl/init_command_sequencer_if.sv
// Decoded CPU write channel from the 8259A bus control logic into the sequencer.
interface init_command_sequencer_if;
    import init_command_sequencer_pkg::*;

    logic              write_strobe;
    logic              A0;
    logic [DATA_W-1:0] internal_bus;

    modport master (output write_strobe, output A0, output internal_bus);
    modport slave  (input  write_strobe, input  A0, input  internal_bus);

endinterface

// File: rtl/init_command_sequencer.sv
// 8259A initialization/operation command sequencer: walks ICW1..ICW4, holds the
// command registers and issues one-cycle ICW1/OCW2/poll pulses.
module init_command_sequencer
    import init_command_sequencer_pkg::*;
#(
    parameter bit                CASCADE_EN      = 1'b1,
    parameter logic [DATA_W-1:0] IMR_RESET_VALUE = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset_bar,
    init_command_sequencer_if.slave    cpu,
    output logic                       init_done,
    output logic                       icw1_pulse,
    output logic                       ltim,
    output logic                       sngl,
    output logic [VEC_W-1:0]           vector_base,
    output logic [DATA_W-1:0]          cascade_cfg,
    output logic                       aeoi,
    output logic                       sfnm,
    output logic                       buf_mode,
    output logic                       m_s,
    output logic [DATA_W-1:0]          imr,
    output logic                       ocw2_pulse,
    output logic [CMD_W-1:0]           ocw2_cmd,
    output logic [LVL_W-1:0]           ocw2_level,
    output logic                       rotate_aeoi,
    output logic                       special_mask,
    output logic                       poll_pulse,
    output logic                       read_isr
);

    seq_state_e        state_q, state_d;
    cpu_wr_t           wr_c;
    wr_kind_e          kind_c;
    logic [CMD_W-1:0]  wr_cmd_c;

    logic icw1_we_c, icw2_we_c, icw3_we_c, icw4_we_c;
    logic ocw1_we_c, ocw2_we_c, ocw3_we_c;

    logic              init_done_q, icw1_pulse_q, ocw2_pulse_q, poll_pulse_q;
    logic              ltim_q, sngl_q, ic4_q;
    logic [VEC_W-1:0]  vector_base_q;
    logic [DATA_W-1:0] cascade_cfg_q, imr_q;
    logic              aeoi_q, sfnm_q, buf_mode_q, m_s_q;
    logic [CMD_W-1:0]  ocw2_cmd_q;
    logic [LVL_W-1:0]  ocw2_level_q;
    logic              rotate_aeoi_q, special_mask_q, read_isr_q;

    assign wr_c     = '{a0: cpu.A0, data: cpu.internal_bus};
    assign kind_c   = decode_write(cpu.write_strobe, wr_c);
    assign wr_cmd_c = wr_c.data[OCW2_CMD_LSB +: CMD_W];

    // Next-state and register write enables; ICW1 restarts from any state.
    always_comb begin
        state_d   = state_q;
        icw1_we_c = 1'b0;
        icw2_we_c = 1'b0;
        icw3_we_c = 1'b0;
        icw4_we_c = 1'b0;
        ocw1_we_c = 1'b0;
        ocw2_we_c = 1'b0;
        ocw3_we_c = 1'b0;

        if (kind_c == WR_ICW1) begin
            icw1_we_c = 1'b1;
            state_d   = ST_WAIT_ICW2;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_WAIT_ICW2: begin
                    if (kind_c == WR_A0) begin
                        icw2_we_c = 1'b1;
                        if (!sngl_q && CASCADE_EN) state_d = ST_WAIT_ICW3;
                        else if (ic4_q)            state_d = ST_WAIT_ICW4;
                        else                       state_d = ST_READY;
                    end
                end
                ST_WAIT_ICW3: begin
                    if (kind_c == WR_A0) begin
                        icw3_we_c = 1'b1;
                        state_d   = ic4_q ? ST_WAIT_ICW4 : ST_READY;
                    end
                end
                ST_WAIT_ICW4: begin
                    if (kind_c == WR_A0) begin
                        icw4_we_c = 1'b1;
                        state_d   = ST_READY;
                    end
                end
                ST_READY: begin
                    case (kind_c)
                        WR_A0:   ocw1_we_c = 1'b1;
                        WR_OCW2: ocw2_we_c = 1'b1;
                        WR_OCW3: ocw3_we_c = 1'b1;
                        default: ;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Command registers and one-cycle pulses, all updated at the sampling edge.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            init_done_q    <= 1'b0;
            icw1_pulse_q   <= 1'b0;
            ocw2_pulse_q   <= 1'b0;
            poll_pulse_q   <= 1'b0;
            ltim_q         <= 1'b0;
            sngl_q         <= 1'b0;
            ic4_q          <= 1'b0;
            vector_base_q  <= '0;
            cascade_cfg_q  <= '0;
            aeoi_q         <= 1'b0;
            sfnm_q         <= 1'b0;
            buf_mode_q     <= 1'b0;
            m_s_q          <= 1'b0;
            imr_q          <= IMR_RESET_VALUE;
            ocw2_cmd_q     <= '0;
            ocw2_level_q   <= '0;
            rotate_aeoi_q  <= 1'b0;
            special_mask_q <= 1'b0;
            read_isr_q     <= 1'b0;
        end else begin
            init_done_q  <= (state_d == ST_READY);
            icw1_pulse_q <= icw1_we_c;
            ocw2_pulse_q <= ocw2_we_c;
            poll_pulse_q <= ocw3_we_c && wr_c.data[OCW3_P_BIT];

            if (icw1_we_c) begin
                ltim_q         <= wr_c.data[ICW1_LTIM_BIT];
                sngl_q         <= CASCADE_EN ? wr_c.data[ICW1_SNGL_BIT] : 1'b1;
                ic4_q          <= wr_c.data[ICW1_IC4_BIT];
                imr_q          <= IMR_RESET_VALUE;
                special_mask_q <= 1'b0;
                read_isr_q     <= 1'b0;
                rotate_aeoi_q  <= 1'b0;
                // Without ICW4 the ICW4-controlled modes fall back to their defaults.
                if (!wr_c.data[ICW1_IC4_BIT]) begin
                    aeoi_q     <= 1'b0;
                    sfnm_q     <= 1'b0;
                    buf_mode_q <= 1'b0;
                    m_s_q      <= 1'b0;
                end
            end

            if (icw2_we_c) vector_base_q <= wr_c.data[DATA_W-1 -: VEC_W];
            if (icw3_we_c) cascade_cfg_q <= wr_c.data;

            if (icw4_we_c) begin
                sfnm_q     <= wr_c.data[ICW4_SFNM_BIT];
                buf_mode_q <= wr_c.data[ICW4_BUF_BIT];
                m_s_q      <= wr_c.data[ICW4_MS_BIT];
                aeoi_q     <= wr_c.data[ICW4_AEOI_BIT];
            end

            if (ocw1_we_c) imr_q <= wr_c.data;

            if (ocw2_we_c) begin
                ocw2_cmd_q   <= wr_cmd_c;
                ocw2_level_q <= wr_c.data[OCW2_LVL_LSB +: LVL_W];
                if (wr_cmd_c == OCW2_ROT_AEOI_SET)      rotate_aeoi_q <= 1'b1;
                else if (wr_cmd_c == OCW2_ROT_AEOI_CLR) rotate_aeoi_q <= 1'b0;
            end

            if (ocw3_we_c) begin
                if (wr_c.data[OCW3_ESMM_BIT]) special_mask_q <= wr_c.data[OCW3_SMM_BIT];
                if (wr_c.data[OCW3_RR_BIT])   read_isr_q     <= wr_c.data[OCW3_RIS_BIT];
            end
        end
    end

    assign init_done    = init_done_q;
    assign icw1_pulse   = icw1_pulse_q;
    assign ltim         = ltim_q;
    assign sngl         = sngl_q;
    assign vector_base  = vector_base_q;
    assign cascade_cfg  = cascade_cfg_q;
    assign aeoi         = aeoi_q;
    assign sfnm         = sfnm_q;
    assign buf_mode     = buf_mode_q;
    assign m_s          = m_s_q;
    assign imr          = imr_q;
    assign ocw2_pulse   = ocw2_pulse_q;
    assign ocw2_cmd     = ocw2_cmd_q;
    assign ocw2_level   = ocw2_level_q;
    assign rotate_aeoi  = rotate_aeoi_q;
    assign special_mask = special_mask_q;
    assign poll_pulse   = poll_pulse_q;
    assign read_isr     = read_isr_q;

endmodule

// File: tb/tb_init_command_sequencer.sv
// Bench for init_command_sequencer: table of CPU writes with expected register
// snapshots fed through a scoreboard queue, plus hand-written pulse/reset sequences.
module tb_init_command_sequencer;
    import init_command_sequencer_pkg::*;

    // flags = {ltim, sngl, aeoi, sfnm, buf_mode, m_s, rotate_aeoi, special_mask}
    // pulses = {icw1_pulse, ocw2_pulse, poll_pulse}; o2 = {ocw2_cmd, ocw2_level}
    typedef struct packed {
        logic       done;
        logic [2:0] pulses;
        logic [7:0] flags;
        logic       ris;
        logic [4:0] vb;
        logic [7:0] casc;
        logic [7:0] imr;
        logic [5:0] o2;
    } obs_t;

    typedef struct packed {
        logic       a0;
        logic [7:0] data;
        obs_t       exp;
    } vec_t;

    localparam int unsigned NVEC = 18;

    logic       clk;
    logic       reset_bar;
    logic       init_done, icw1_pulse, ltim, sngl, aeoi, sfnm, buf_mode, m_s;
    logic       ocw2_pulse, rotate_aeoi, special_mask, poll_pulse, read_isr;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg, imr;
    logic [2:0] ocw2_cmd, ocw2_level;

    init_command_sequencer_if bus ();

    init_command_sequencer #(
        .CASCADE_EN      (1'b1),
        .IMR_RESET_VALUE (8'h00)
    ) dut (
        .clk          (clk),
        .reset_bar    (reset_bar),
        .cpu          (bus),
        .init_done    (init_done),
        .icw1_pulse   (icw1_pulse),
        .ltim         (ltim),
        .sngl         (sngl),
        .vector_base  (vector_base),
        .cascade_cfg  (cascade_cfg),
        .aeoi         (aeoi),
        .sfnm         (sfnm),
        .buf_mode     (buf_mode),
        .m_s          (m_s),
        .imr          (imr),
        .ocw2_pulse   (ocw2_pulse),
        .ocw2_cmd     (ocw2_cmd),
        .ocw2_level   (ocw2_level),
        .rotate_aeoi  (rotate_aeoi),
        .special_mask (special_mask),
        .poll_pulse   (poll_pulse),
        .read_isr     (read_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t dut_obs;
    assign dut_obs = obs_t'({init_done, icw1_pulse, ocw2_pulse, poll_pulse,
                             ltim, sngl, aeoi, sfnm, buf_mode, m_s, rotate_aeoi, special_mask,
                             read_isr, vector_base, cascade_cfg, imr, ocw2_cmd, ocw2_level});

    int   checks = 0;
    int   errors = 0;
    int   wr_idx = 0;
    obs_t exp_q[$];
    obs_t mon_e;
    logic seen_q;
    vec_t tbl [NVEC];

    function automatic obs_t mk(input logic done, input logic [2:0] p, input logic [7:0] f,
                                input logic ris, input logic [4:0] vb, input logic [7:0] cc,
                                input logic [7:0] im, input logic [5:0] o2);
        obs_t o;
        o = '{done, p, f, ris, vb, cc, im, o2};
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Called at a falling edge; drives one strobe cycle and queues its expected result.
    task automatic wr(input logic a0, input logic [7:0] d, input obs_t exp);
        bus.write_strobe = 1'b1;
        bus.A0           = a0;
        bus.internal_bus = d;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.write_strobe = 1'b0;
    endtask

    always @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) seen_q <= 1'b0;
        else            seen_q <= bus.write_strobe;
    end

    // Scoreboard: the cycle after each sampled strobe, compare against the queued snapshot.
    always @(negedge clk) begin
        if (seen_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got output with no expected entry at write %0d", wr_idx);
            end else begin
                mon_e = exp_q.pop_front();
                check_obs($sformatf("write%0d", wr_idx), dut_obs, mon_e);
            end
            wr_idx++;
        end
    end

    initial begin
        obs_t zero;
        int   wait_cyc;
        zero = mk(1'b0, 3'b000, 8'h00, 1'b0, 5'h00, 8'h00, 8'h00, 6'h00);

        tbl[0]  = '{1'b1, 8'hFF, zero};
        tbl[1]  = '{1'b0, 8'h13, mk(1'b0, 3'b100, 8'h40, 1'b0, 5'h00, 8'h00, 8'h00, 6'h00)};
        tbl[2]  = '{1'b1, 8'h20, mk(1'b0, 3'b000, 8'h40, 1'b0, 5'h04, 8'h00, 8'h00, 6'h00)};
        tbl[3]  = '{1'b0, 8'h63, mk(1'b0, 3'b000, 8'h40, 1'b0, 5'h04, 8'h00, 8'h00, 6'h00)};
        tbl[4]  = '{1'b1, 8'h03, mk(1'b1, 3'b000, 8'h60, 1'b0, 5'h04, 8'h00, 8'h00, 6'h00)};
        tbl[5]  = '{1'b0, 8'h11, mk(1'b0, 3'b100, 8'h20, 1'b0, 5'h04, 8'h00, 8'h00, 6'h00)};
        tbl[6]  = '{1'b1, 8'h08, mk(1'b0, 3'b000, 8'h20, 1'b0, 5'h01, 8'h00, 8'h00, 6'h00)};
        tbl[7]  = '{1'b1, 8'h04, mk(1'b0, 3'b000, 8'h20, 1'b0, 5'h01, 8'h04, 8'h00, 6'h00)};
        tbl[8]  = '{1'b1, 8'h1D, mk(1'b1, 3'b000, 8'h1C, 1'b0, 5'h01, 8'h04, 8'h00, 6'h00)};
        tbl[9]  = '{1'b1, 8'hA5, mk(1'b1, 3'b000, 8'h1C, 1'b0, 5'h01, 8'h04, 8'hA5, 6'h00)};
        tbl[10] = '{1'b0, 8'h63, mk(1'b1, 3'b010, 8'h1C, 1'b0, 5'h01, 8'h04, 8'hA5, 6'h1B)};
        tbl[11] = '{1'b0, 8'h0B, mk(1'b1, 3'b000, 8'h1C, 1'b1, 5'h01, 8'h04, 8'hA5, 6'h1B)};
        tbl[12] = '{1'b0, 8'h68, mk(1'b1, 3'b000, 8'h1D, 1'b1, 5'h01, 8'h04, 8'hA5, 6'h1B)};
        tbl[13] = '{1'b0, 8'h0C, mk(1'b1, 3'b001, 8'h1D, 1'b1, 5'h01, 8'h04, 8'hA5, 6'h1B)};
        tbl[14] = '{1'b0, 8'h80, mk(1'b1, 3'b010, 8'h1F, 1'b1, 5'h01, 8'h04, 8'hA5, 6'h20)};
        tbl[15] = '{1'b0, 8'h00, mk(1'b1, 3'b010, 8'h1D, 1'b1, 5'h01, 8'h04, 8'hA5, 6'h00)};
        tbl[16] = '{1'b0, 8'h1A, mk(1'b0, 3'b100, 8'hC0, 1'b0, 5'h01, 8'h04, 8'h00, 6'h00)};
        tbl[17] = '{1'b1, 8'hF8, mk(1'b1, 3'b000, 8'hC0, 1'b0, 5'h1F, 8'h04, 8'h00, 6'h00)};

        reset_bar        = 1'b0;
        bus.write_strobe = 1'b0;
        bus.A0           = 1'b0;
        bus.internal_bus = 8'h00;
        repeat (3) @(negedge clk);
        check_obs("reset_state", dut_obs, zero);
        reset_bar = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) wr(tbl[i].a0, tbl[i].data, tbl[i].exp);

        // OCW2 pulse must last exactly one cycle; command/level stay readable afterwards.
        wr(1'b0, 8'h21, mk(1'b1, 3'b010, 8'hC0, 1'b0, 5'h1F, 8'h04, 8'h00, 6'h09));
        @(negedge clk);
        check_bit("ocw2_pulse_width", ocw2_pulse, 1'b0);
        bus.A0           = 1'b0;
        bus.internal_bus = 8'h13;
        @(negedge clk);
        check_obs("no_strobe_hold", dut_obs, mk(1'b1, 3'b000, 8'hC0, 1'b0, 5'h1F, 8'h04, 8'h00, 6'h09));

        // Asynchronous reset in the middle of a cascade init sequence.
        wr(1'b0, 8'h11, mk(1'b0, 3'b100, 8'h00, 1'b0, 5'h1F, 8'h04, 8'h00, 6'h09));
        wr(1'b1, 8'h08, mk(1'b0, 3'b000, 8'h00, 1'b0, 5'h01, 8'h04, 8'h00, 6'h09));
        #2 reset_bar = 1'b0;
        #1 check_obs("async_reset_mid_seq", dut_obs, zero);
        @(negedge clk);
        reset_bar = 1'b1;

        // Back in IDLE: A0=1 and OCW2/OCW3 writes are ignored.
        wr(1'b1, 8'hFF, zero);
        wr(1'b0, 8'h63, zero);
        wr(1'b0, 8'h0C, zero);

        @(negedge clk);
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
